// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, master FSM states and UART bridge register map
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    // Register offsets of the UART AXI4-Lite bridge this master is meant to drive
    localparam logic [3:0] UART_RX_FIFO = 4'h0;
    localparam logic [3:0] UART_TX_FIFO = 4'h4;
    localparam logic [3:0] UART_STAT    = 4'h8;
    localparam logic [3:0] UART_CTRL    = 4'hC;

endpackage

// File: rtl/axil_lite_master_if.sv
// rtl/axil_lite_master_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_lite_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axil_lite_master.sv
// rtl/axil_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response port
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_ERR_CNT_WIDTH    = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_we,
    output logic [C_ERR_CNT_WIDTH-1:0]      err_count,
    axil_lite_master_if.master              m_axi
);

    state_t                            state, state_next;
    logic                              aw_done, w_done, aw_fire, w_fire;
    logic                              resp_take;
    axi_resp_t                         resp_in, resp_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic                              we_q;
    logic [C_ERR_CNT_WIDTH-1:0]        err_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            resp_q  <= OKAY;
            err_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                we_q    <= cmd_we;
            end
            // Done flags live only while both write channels are still being negotiated
            if (state == WR_REQ && state_next == WR_REQ) begin
                aw_done <= aw_done | aw_fire;
                w_done  <= w_done | w_fire;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (resp_take) begin
                resp_q  <= resp_in;
                rdata_q <= (state == RD_DATA) ? m_axi.M_AXI_RDATA : '0;
                if (resp_in != OKAY && err_q != '1)
                    err_q <= err_q + C_ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next           = state;
        cmd_ready            = 1'b0;
        rsp_valid            = 1'b0;
        aw_fire              = 1'b0;
        w_fire               = 1'b0;
        resp_take            = 1'b0;
        resp_in              = axi_resp_t'(m_axi.M_AXI_BRESP);
        m_axi.M_AXI_AWVALID  = 1'b0;
        m_axi.M_AXI_WVALID   = 1'b0;
        m_axi.M_AXI_BREADY   = 1'b0;
        m_axi.M_AXI_ARVALID  = 1'b0;
        m_axi.M_AXI_RREADY   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = M_AXI_ARESETN;
                if (cmd_valid)
                    state_next = cmd_we ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                m_axi.M_AXI_AWVALID = !aw_done;
                m_axi.M_AXI_WVALID  = !w_done;
                aw_fire = !aw_done && m_axi.M_AXI_AWREADY;
                w_fire  = !w_done && m_axi.M_AXI_WREADY;
                if ((aw_done || aw_fire) && (w_done || w_fire))
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                m_axi.M_AXI_BREADY = 1'b1;
                if (m_axi.M_AXI_BVALID) begin
                    resp_take  = 1'b1;
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                m_axi.M_AXI_ARVALID = 1'b1;
                if (m_axi.M_AXI_ARREADY)
                    state_next = RD_DATA;
            end
            RD_DATA: begin
                m_axi.M_AXI_RREADY = 1'b1;
                resp_in = axi_resp_t'(m_axi.M_AXI_RRESP);
                if (m_axi.M_AXI_RVALID) begin
                    resp_take  = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_axi.M_AXI_AWADDR = addr_q;
    assign m_axi.M_AXI_ARADDR = addr_q;
    assign m_axi.M_AXI_AWPROT = 3'b000;
    assign m_axi.M_AXI_ARPROT = 3'b000;
    assign m_axi.M_AXI_WDATA  = wdata_q;
    assign m_axi.M_AXI_WSTRB  = wstrb_q;
    assign rsp_rdata          = rdata_q;
    assign rsp_resp           = resp_q;
    assign rsp_we             = we_q;
    assign err_count          = err_q;

endmodule

// File: doc/axil_lite_master.md
# axil_lite_master

AXI4-Lite initiator that turns a simple single-beat command/response interface into AXI4-Lite write and read transactions. It is the master-side counterpart of the UART AXI4-Lite bridge: it lets on-chip logic, or a bench-level command source, program and poll the UART register file over the real bus instead of driving the raw UART signals. It allows one outstanding transaction at a time and counts error responses.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be 32 or 64
- C_ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP of the transaction
- rsp_we  out  1  echo of cmd_we
- err_count  out  C_ERR_CNT_WIDTH  saturating count of non-OKAY responses
- Write address channel: M_AXI_AWADDR out, M_AXI_AWVALID out, M_AXI_AWREADY in, M_AXI_AWPROT out 3 (tied 3'b000)
- Write data channel: M_AXI_WDATA out, M_AXI_WSTRB out, M_AXI_WVALID out, M_AXI_WREADY in
- Write response channel: M_AXI_BRESP in 2, M_AXI_BVALID in, M_AXI_BREADY out
- Read address channel: M_AXI_ARADDR out, M_AXI_ARVALID out, M_AXI_ARREADY in, M_AXI_ARPROT out 3 (tied 3'b000)
- Read data channel: M_AXI_RDATA in, M_AXI_RRESP in 2, M_AXI_RVALID in, M_AXI_RREADY out

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On handshake, latch addr, wdata, wstrb and we.
  - cmd_we=1 → WR_REQ; cmd_we=0 → RD_REQ.
- WR_REQ: AWVALID and WVALID assert together. Each channel drops independently on its own READY; done flags aw_done and w_done are kept.
  - Same-cycle AWREADY and WREADY are legal.
  - When both flags are set (including in the same cycle) → WR_RESP.
- WR_RESP: BREADY=1. On BVALID, latch BRESP, set rsp_rdata=0 → RSP.
- RD_REQ: ARVALID=1 until ARREADY → RD_DATA.
- RD_DATA: RREADY=1. On RVALID, latch RDATA and RRESP → RSP.
- RSP: rsp_valid=1, held stable until rsp_ready → IDLE.
  - rsp_valid and cmd_ready are never high in the same cycle; no back-to-back overlap.
- err_count increments by 1 on each latched resp ≠ 2'b00 and saturates at all-ones.
- VALID is never withdrawn and address/data never change before the matching READY (AXI rule).
- Bus READY/VALID are ignored in states where they are not expected.

## Timing
- Reset values: cmd_ready=0 while in reset, 1 in IDLE from the first cycle after release. All other outputs are 0, including every *VALID, BREADY, RREADY, rsp_* and err_count.
- Reset mid-transaction:
  - Returns the FSM to IDLE and clears all VALIDs and the done flags immediately (asynchronous).
  - No response is generated; the slave is reset by the same signal.
- All AXI outputs are registered and come from FSM/state flops; none depend combinationally on *READY inputs.
- Latency, zero-wait slave (READY high, response next cycle):
  - Write: cmd handshake at T; AW/W valid T+1; BREADY T+2, BVALID seen T+2; rsp_valid T+3.
  - Read: cmd at T; ARVALID T+1; RDATA T+2; rsp_valid T+3.
- Minimum command-to-command interval: 4 cycles, with rsp_ready tied high.

## Structure
- Package axil_pkg:
  - typedef for axi_resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - FSM state enum.
  - UART bridge register offset constants (RX_FIFO 0x0, TX_FIFO 0x4, STAT 0x8, CTRL 0xC), shared with the bridge.
- Single module, no sub-module. The write-phase AW/W done-flag tracking stays inline.

## Test plan
- Write 0x0000_0041 to 0x4, wstrb 4'hF, zero-wait slave → AWADDR=0x4, WDATA=0x41 on T+1; rsp_valid T+3 with rsp_resp=0, rsp_we=1.
- Skewed write: AWREADY after 3 cycles, WREADY after 1 → WVALID drops after cycle 1, AWVALID held 3 cycles with stable AWADDR; exactly one B handshake.
- Read 0x8 with 5-cycle RVALID delay, RDATA=0x0000_0004 → rsp_rdata=0x4; RREADY held until RVALID.
- Response back-pressure: rsp_ready low 10 cycles → rsp_valid and data held stable, cmd_ready=0 throughout.
- Slave returns SLVERR on 300 consecutive writes → err_count saturates at 255, rsp_resp=2'b10.
- Deassert ARESETN during RD_DATA → all VALID/READY outputs go to 0 asynchronously, no rsp_valid; after release a new read completes normally.
